// File: rtl/compadder_seq_ctrl_pkg.sv
// Shared definitions for the chunked adder sequencer: FSM state encoding and
// default geometry (WIDTH-bit chunks, CHUNKS chunks per operation).
package compadder_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH  = 3;
  localparam int unsigned DEF_CHUNKS = 4;

endpackage

// File: rtl/compadder_seq_ctrl_compadder.sv
// Compadder chunk datapath: produces both a+b and a+b+1 for one WIDTH-bit
// chunk so the caller can pick the result by carry without rippling.
// Ports:
//   a, b   in  WIDTH     chunk operands
//   sum_c  out WIDTH+1   a + b        (MSB is carry-out)
//   tum    out WIDTH+1   a + b + 1    (MSB is carry-out)
module compadder_seq_ctrl_compadder
  import compadder_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum_c,
  output logic [WIDTH:0]   tum
);

  always_comb begin
    sum_c = {1'b0, a} + {1'b0, b};
    tum   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
  end

endmodule

// File: rtl/compadder_seq_ctrl.sv
// Multi-cycle wide adder: adds two N-bit operands (N = WIDTH*CHUNKS) through
// one shared chunk adder, one chunk per clock, LSB chunk first. Each cycle the
// running carry selects the chunk's sum or sum+1 output.
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request, honoured only in IDLE or DONE
//   a, b   in   N  operands, captured on accepted start
//   cin    in   1  carry-in, captured on accepted start
//   busy   out  1  high while chunks are being processed
//   done   out  1  one-cycle pulse, sum/cout valid from this cycle
//   sum    out  N  result register
//   cout   out  1  final carry-out
module compadder_seq_ctrl
  import compadder_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CHUNKS = DEF_CHUNKS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH*CHUNKS-1:0] a,
  input  logic [WIDTH*CHUNKS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*CHUNKS-1:0] sum,
  output logic                    cout
);

  localparam int unsigned N     = WIDTH * CHUNKS;
  localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

  state_t           state, state_next;
  logic [N-1:0]     a_r, a_r_next;
  logic [N-1:0]     b_r, b_r_next;
  logic             carry, carry_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [N-1:0]     sum_next;
  logic             cout_next, busy_next, done_next;

  logic [WIDTH-1:0] a_c, b_c;
  logic [WIDTH:0]   sum_c, tum, r;

  compadder_seq_ctrl_compadder #(.WIDTH(WIDTH)) u_add (
    .a     (a_c),
    .b     (b_c),
    .sum_c (sum_c),
    .tum   (tum)
  );

  // Chunk mux onto the shared adder and carry-select of its result.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (idx == IDX_W'(k)) begin
        a_c = a_r[k*WIDTH +: WIDTH];
        b_c = b_r[k*WIDTH +: WIDTH];
      end
    end
    r = carry ? tum : sum_c;
  end

  always_comb begin
    state_next = state;
    a_r_next   = a_r;
    b_r_next   = b_r;
    carry_next = carry;
    idx_next   = idx;
    sum_next   = sum;
    cout_next  = cout;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_r_next   = a;
          b_r_next   = b;
          carry_next = cin;
          idx_next   = '0;
          sum_next   = '0;
          cout_next  = 1'b0;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        for (int unsigned k = 0; k < CHUNKS; k++) begin
          if (idx == IDX_W'(k)) sum_next[k*WIDTH +: WIDTH] = r[WIDTH-1:0];
        end
        carry_next = r[WIDTH];
        idx_next   = idx + IDX_W'(1);
        if (idx == LAST) begin
          cout_next  = r[WIDTH];
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // busy/done are registered copies of the next-state decode, so there is
    // no combinational path from start to either output.
    busy_next = (state_next == S_RUN);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      a_r   <= a_r_next;
      b_r   <= b_r_next;
      carry <= carry_next;
      idx   <= idx_next;
      sum   <= sum_next;
      cout  <= cout_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_compadder_seq_ctrl.sv
// Self-checking bench for compadder_seq_ctrl (WIDTH=3, CHUNKS=4, N=12).
// Expected {cout,sum} values are queued when an operation is issued and
// compared whenever the design raises done.
module tb_compadder_seq_ctrl;
  import compadder_seq_ctrl_pkg::*;

  localparam int unsigned W  = DEF_WIDTH;
  localparam int unsigned C  = DEF_CHUNKS;
  localparam int unsigned N  = W * C;
  localparam int          LAT = C + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [N-1:0] sum;

  int errors = 0;
  int checks = 0;
  logic [N:0] sb[$];
  logic [N:0] last_exp;

  compadder_seq_ctrl #(.WIDTH(W), .CHUNKS(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) check_eq("spurious_done", 1, 0);
      else check_eq("result", {cout, sum}, sb.pop_front());
    end
  end

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + (N+1)'(c);
  endfunction

  // Drive start with operands; the following rising edge accepts it.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    last_exp = model(x, y, c);
    sb.push_back(last_exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; checks latency and number of busy cycles.
  task automatic wait_done(input int exp_lat);
    int n = 0;
    int nb = 0;
    bit got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1;
      else if (busy === 1'b1) nb++;
    end
    check_eq("done_seen", 64'(got), 1);
    if (got) begin
      check_eq("latency", n, exp_lat);
      check_eq("busy_cycles", nb, exp_lat - 1);
    end
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    @(posedge clk); #1;
    issue(x, y, c);
    wait_done(LAT);
    @(negedge clk);
    check_eq("done_pulse", 64'(done), 0);
    check_eq("idle_busy", 64'(busy), 0);
    repeat (2) @(negedge clk);
    check_eq("hold", {cout, sum}, last_exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 12'hABC; b = 12'h123; cin = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(done), 0);
    check_eq("rst_sum", 64'(sum), 12'h000);
    check_eq("rst_cout", 64'(cout), 0);
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 64'(busy), 0);

    run_op(12'h0FF, 12'h001, 1'b0);
    check_eq("op1_sum", 64'(sum), 12'h100);
    run_op(12'hFFF, 12'h001, 1'b0);
    check_eq("ripple_cout", 64'(cout), 1);
    run_op(12'hFFF, 12'h000, 1'b1);
    check_eq("cin_sum", 64'(sum), 12'h000);

    // Start while busy must be ignored.
    @(posedge clk); #1;
    issue(12'h00A, 12'h005, 1'b0);
    @(posedge clk); #1;
    a = 12'h123; b = 12'h456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3);
    check_eq("ignored_sum", 64'(sum), 12'h00F);
    repeat (3) @(negedge clk);
    check_eq("no_queue_busy", 64'(busy), 0);

    // Reset during the second RUN cycle aborts the operation.
    @(posedge clk); #1;
    a = 12'h555; b = 12'h2AA; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 0);
    check_eq("abort_done", 64'(done), 0);
    check_eq("abort_sum", 64'(sum), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("abort_idle", 64'(busy), 0);
    run_op(12'h800, 12'h800, 1'b0);
    check_eq("msb_cout", 64'(cout), 1);

    // Random sweep with corner operands and back-to-back starts in DONE.
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] x, y;
      logic c;
      case ($urandom_range(0, 3))
        0: x = '1;
        1: x = '0;
        default: x = N'($urandom());
      endcase
      case ($urandom_range(0, 3))
        0: y = '1;
        1: y = '0;
        default: y = N'($urandom());
      endcase
      c = 1'($urandom_range(0, 1));
      if (i > 0 && $urandom_range(0, 1) == 1) begin
        // Still in the DONE cycle: issue immediately for back-to-back.
        issue(x, y, c);
      end else begin
        if (i > 0) begin
          @(posedge clk); #1;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        issue(x, y, c);
      end
      wait_done(LAT);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
